// File: rtl/scan_select_if.sv
// Select/handshake bundle between the scan sequencer and its controller.
interface scan_select_if #(
    parameter int unsigned DW = 8
);
    logic          start;
    logic          stop;
    logic          cont;
    logic [7:0]    mask;
    logic [DW-1:0] dwell;
    logic          a;
    logic          b;
    logic          c;
    logic          en;
    logic          busy;
    logic          done;

    // Controller side: issues commands, observes select and status
    modport master (
        output start, stop, cont, mask, dwell,
        input  a, b, c, en, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, stop, cont, mask, dwell,
        output a, b, c, en, busy, done
    );
endinterface

// File: rtl/scan_select_sequencer.sv
// Steps a 3-to-8 decoder select through masked channels with a programmable dwell.
module scan_select_sequencer #(
    parameter int unsigned DW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    scan_select_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [2:0]    sel_q,   sel_d;
    logic          en_q,    en_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [7:0]    mask_q,  mask_d;
    logic          cont_q,  cont_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q,   cnt_d;

    logic [DW-1:0] dwell_eff;
    logic [2:0]    lo_new;
    logic [2:0]    lo_latched;
    logic [3:0]    hi_next;

    // Index of lowest set bit (0 when mask is empty)
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above s
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] s);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(s))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Channel search and dwell normalisation (zero dwell behaves as one cycle)
    always_comb begin
        dwell_eff  = (bus.dwell == '0) ? DW'(1) : bus.dwell;
        lo_new     = lowest_bit(bus.mask);
        lo_latched = lowest_bit(mask_q);
        hi_next    = next_above(mask_q, sel_q);
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mask_d  = mask_q;
        cont_d  = cont_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (bus.start && (bus.mask != 8'd0)) begin
                    mask_d  = bus.mask;
                    cont_d  = bus.cont;
                    dwell_d = dwell_eff;
                    sel_d   = lo_new;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = dwell_eff - DW'(1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                end else begin
                    cnt_d = dwell_q - DW'(1);
                    if (hi_next[3]) begin
                        sel_d = hi_next[2:0];
                    end else if (cont_q) begin
                        sel_d = lo_latched;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= 8'd0;
            cont_q  <= 1'b0;
            dwell_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.a    = sel_q[2];
    assign bus.b    = sel_q[1];
    assign bus.c    = sel_q[0];
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed bench for scan_select_sequencer; observed word is {a,b,c,en,busy,done}.
module tb_scan_select_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    scan_select_if #(.DW(8)) bus ();

    scan_select_sequencer #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [5:0] obs;
    assign obs = {bus.a, bus.b, bus.c, bus.en, bus.busy, bus.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        rst_n = 1'b0;
        tick();
        tick();
        exp = 6'b000_000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_held got=%b exp=%b", obs, exp); end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL reset_idle[%0d] got=%b exp=%b", k, obs, exp); end
        end
    endtask

    task automatic test_single_frame();
        logic [5:0] exp;
        logic [2:0] seq [8];
        seq = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
        bus.mask  = 8'b1010_0101;
        bus.dwell = 8'd2;
        bus.cont  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = {seq[k], 3'b110};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL frame[%0d] got=%b exp=%b", k, obs, exp); end
            tick();
        end
        exp = {3'd7, 3'b001};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL frame_done got=%b exp=%b", obs, exp); end
        tick();
        exp = {3'd7, 3'b000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL frame_done_pulse got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_cont_wrap();
        logic [5:0] exp;
        bus.mask  = 8'b1000_0001;
        bus.dwell = 8'd0;
        bus.cont  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = {((k % 2) == 1) ? 3'd7 : 3'd0, 3'b110};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL wrap[%0d] got=%b exp=%b", k, obs, exp); end
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        exp = {3'd0, 3'b000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL wrap_stop got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_stop_vs_expiry();
        logic [5:0] exp;
        bus.mask  = 8'b0001_0010;
        bus.dwell = 8'd3;
        bus.cont  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = {3'd1, 3'b110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stop_first got=%b exp=%b", obs, exp); end
        tick();
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stop_last_dwell got=%b exp=%b", obs, exp); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        exp = {3'd1, 3'b000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stop_expiry got=%b exp=%b", obs, exp); end
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stop_after got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_ignored_inputs();
        logic [5:0] exp;
        bus.mask  = 8'd0;
        bus.dwell = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = {3'd1, 3'b000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL empty_mask got=%b exp=%b", obs, exp); end
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL empty_mask_hold got=%b exp=%b", obs, exp); end
        bus.mask  = 8'b0100_1000;
        bus.dwell = 8'd1;
        bus.cont  = 1'b0;
        bus.start = 1'b1;
        tick();
        exp = {3'd3, 3'b110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_first got=%b exp=%b", obs, exp); end
        bus.mask  = 8'hFF;
        bus.dwell = 8'd5;
        bus.cont  = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = {3'd6, 3'b110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_second got=%b exp=%b", obs, exp); end
        tick();
        exp = {3'd6, 3'b001};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL mid_done got=%b exp=%b", obs, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        bus.mask  = 8'b0010_0110;
        bus.dwell = 8'd1;
        bus.cont  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        exp = {3'd5, 3'b110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rst_mid_pre got=%b exp=%b", obs, exp); end
        rst_n = 1'b0;
        tick();
        exp = 6'b000_000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rst_mid got=%b exp=%b", obs, exp); end
        rst_n     = 1'b1;
        bus.mask  = 8'b0010_0100;
        bus.dwell = 8'd2;
        bus.cont  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = {3'd2, 3'b110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rst_restart got=%b exp=%b", obs, exp); end
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rst_restart_hold got=%b exp=%b", obs, exp); end
        tick();
        exp = {3'd5, 3'b110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rst_restart_next got=%b exp=%b", obs, exp); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.cont  = 1'b0;
        bus.mask  = 8'd0;
        bus.dwell = 8'd0;
        test_reset();
        test_single_frame();
        test_cont_wrap();
        test_stop_vs_expiry();
        test_ignored_inputs();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
